locked_seq_multiplier: RTL and testbench
========================================

# locked_seq_multiplier

Parametrised, key-locked, iterative shift-add multiplier: WIDTH x WIDTH unsigned operands, 2*WIDTH result, one multiplier bit retired per clock. Successor to the combinational 8-bit XOR-locked multiplier. Adds a start/done handshake, parametrised width and key length, and a fully specified corruption function for wrong keys, so locked-netlist simulations can predict every wrong-key output exactly. Sits in the obfuscation benchmark set as the sequential member of the multiplier family.

## Interface
- WIDTH, 8, operand width in bits, must be ≥ 2.
- KEY_WIDTH, 64, key length in bits, must be ≥ WIDTH.
- KEY_CORRECT, 64'h192F7F0351667DEC, hardwired unlocking key, KEY_WIDTH bits.
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  request a multiply; sampled only in IDLE or DONE.
- operand1_i  in  WIDTH  multiplicand A.
- operand2_i  in  WIDTH  multiplier B.
- keyinput  in  KEY_WIDTH  unlocking key.
- busy_o  out  1  high while in RUN.
- done_o  out  1  one-cycle pulse when result_o is updated.
- result_o  out  2*WIDTH  product, held until the next completion.

## Operation
- **Latching:** on an accepted start, A, B and keyinput are latched. Later changes on the inputs do not affect the operation in flight.
- **Mismatch vector:** m = keyinput ^ KEY_CORRECT, computed from the latched key.
- **Flip vector:** G is WIDTH bits. G[k] is the XOR of all m[j] with j mod WIDTH == k.
- **Effective multiplier:** B' = B ^ G.
- **Result:** result = A * B', unsigned and exact in 2*WIDTH bits; overflow is impossible.
- **Correct key:** any key whose mismatches cancel pairwise in every residue class produces the true product. Such keys are intentionally equivalent keys.
- **FSM states:** IDLE, RUN, DONE.
  - IDLE: if start_i, latch, clear the accumulator, set count=0, go to RUN.
  - RUN: if B'[count], add A<<count to the 2*WIDTH-bit accumulator. Increment count. When count==WIDTH-1, register the final sum into result_o and go to DONE.
  - DONE: assert done_o. If start_i, latch and go to RUN (back-to-back); otherwise go to IDLE.
- **start_i during RUN:** ignored. It is not queued.
- **Reset values:** busy_o=0, done_o=0, result_o=0, state=IDLE, count=0, accumulator=0.
- **Reset mid-RUN:** aborts the operation. No done_o is produced and result_o reads 0.

## Timing
- start_i high at edge N (state IDLE or DONE) → busy_o high from edge N through edge N+WIDTH-1.
- result_o is updated at edge N+WIDTH. done_o is high for exactly the cycle following edge N+WIDTH.
- Latency is WIDTH clocks from start to done. Maximum throughput is one result per WIDTH+1 clocks (back-to-back through DONE).
- busy_o and done_o are never high together.
- result_o changes only at the completion edge or on reset.
- The accumulator add is a single-cycle 2*WIDTH-bit adder; there are no multicycle paths.

## Test plan
- **Correct key:** defaults, A=0x29, B=0x7A, keyinput=KEY_CORRECT → done_o one cycle at start+8, result_o=0x138A, busy_o high for 8 cycles.
- **Single-bit wrong key:** keyinput=64'h192F7F0351667DE8 (m bit 2), A=0x29, B=0x7A → B'=0x7E, result_o=0x142E.
- **Cancelling mismatch:** keyinput=64'h192F7F0351667CED (m bits 0 and 8 cancel) with A=0x29, B=0x7A → result_o=0x138A. Separately, keyinput=64'h190F7F0351627DEC (m bits 53 and 18 → G=0x24) with A=0x29, B=0x7A → B'=0x5E, result_o=0x0F0E.
- **Edge operands, correct key:**
  - A=0xFF, B=0xFF → 0xFE01.
  - A=0x80, B=0x80 → 0x4000.
  - A=0xAB, B=0x00 → 0x0000.
  - A=0x00, B=0x01 → 0x0000.
- **Handshake:**
  - Back-to-back start in the DONE cycle (0x11*0x11 then 0x34*0x12) → done pulses 9 cycles apart, results 0x0121 then 0x03A8.
  - start_i pulsed mid-RUN is ignored.
  - Operands changed mid-RUN do not alter the result.
- **Reset:** assert rst_i asynchronously 4 cycles into RUN → outputs go to 0 immediately, with no done_o. After release, a new start with 0x40*0x20 → 0x0800.

Source files
------------

// File: rtl/locked_seq_multiplier_if.sv
// Request/response bundle for the key-locked sequential multiplier.
// Master drives operands and key, slave returns status and product.
interface locked_seq_multiplier_if #(
    parameter int WIDTH     = 8,
    parameter int KEY_WIDTH = 64
);
    logic                   start_i;
    logic [WIDTH-1:0]       operand1_i;
    logic [WIDTH-1:0]       operand2_i;
    logic [KEY_WIDTH-1:0]   keyinput;
    logic                   busy_o;
    logic                   done_o;
    logic [2*WIDTH-1:0]     result_o;

    modport master (
        output start_i,
        output operand1_i,
        output operand2_i,
        output keyinput,
        input  busy_o,
        input  done_o,
        input  result_o
    );

    modport slave (
        input  start_i,
        input  operand1_i,
        input  operand2_i,
        input  keyinput,
        output busy_o,
        output done_o,
        output result_o
    );
endinterface

// File: rtl/locked_seq_multiplier.sv
// Key-locked shift-add multiplier, one multiplier bit per clock.
// Wrong keys fold into a flip vector XORed onto the multiplier.
module locked_seq_multiplier #(
    parameter int                   WIDTH       = 8,
    parameter int                   KEY_WIDTH   = 64,
    parameter logic [KEY_WIDTH-1:0] KEY_CORRECT = 64'h192F7F0351667DEC
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    locked_seq_multiplier_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]           state;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]     b_sh;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   result;

    logic [KEY_WIDTH-1:0] mis;
    logic [WIDTH-1:0]     flip;
    logic [2*WIDTH-1:0]   add_term;
    logic [2*WIDTH-1:0]   acc_sum;
    logic                 last;

    // Key bits that share a residue class mod WIDTH cancel pairwise.
    always_comb begin
        mis  = bus.keyinput ^ KEY_CORRECT;
        flip = '0;
        for (int j = 0; j < KEY_WIDTH; j++) begin
            flip[j % WIDTH] = flip[j % WIDTH] ^ mis[j];
        end
    end

    assign add_term = b_sh[0] ? a_sh : '0;
    assign acc_sum  = acc + add_term;
    assign last     = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= S_IDLE;
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            acc    <= '0;
            result <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start_i) begin
                        // The flipped multiplier is captured, so later key
                        // changes cannot disturb the operation in flight.
                        a_sh  <= {{WIDTH{1'b0}}, bus.operand1_i};
                        b_sh  <= bus.operand2_i ^ flip;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    acc  <= acc_sum;
                    a_sh <= a_sh << 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + 1'b1;
                    if (last) begin
                        result <= acc_sum;
                        state  <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy_o   = (state == S_RUN);
    assign bus.done_o   = (state == S_DONE);
    assign bus.result_o = result;
endmodule

// File: tb/tb_locked_seq_multiplier.sv
// Directed-vector bench for the key-locked sequential multiplier.
// Expected products are hand-computed constants.
module tb_locked_seq_multiplier;
    localparam logic [63:0] KEY_OK = 64'h192F7F0351667DEC;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   both_high = 0;

    locked_seq_multiplier_if #(.WIDTH(8), .KEY_WIDTH(64)) bus_if ();

    locked_seq_multiplier dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus_if.busy_o && bus_if.done_o) both_high++;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic kick(input logic [7:0] a, input logic [7:0] b,
                        input logic [63:0] key);
        bus_if.operand1_i = a;
        bus_if.operand2_i = b;
        bus_if.keyinput   = key;
        bus_if.start_i    = 1'b1;
        @(negedge clk);
        bus_if.start_i    = 1'b0;
    endtask

    // Called at the first negedge after the start edge.
    task automatic wait_done(output logic [15:0] res, output int lat,
                             output int busy_cnt);
        lat = 0;
        busy_cnt = 0;
        while (!bus_if.done_o && lat < 30) begin
            if (bus_if.busy_o) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        res = bus_if.result_o;
    endtask

    task automatic mul(input string tag, input logic [7:0] a,
                       input logic [7:0] b, input logic [63:0] key,
                       input logic [15:0] exp);
        logic [15:0] r;
        int lat, bc;
        @(negedge clk);
        kick(a, b, key);
        wait_done(r, lat, bc);
        check(tag, r, exp);
    endtask

    initial begin
        logic [15:0] r;
        int lat, bc, done_seen;

        bus_if.start_i    = 1'b0;
        bus_if.operand1_i = '0;
        bus_if.operand2_i = '0;
        bus_if.keyinput   = KEY_OK;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", bus_if.busy_o, 0);
        check("rst_done", bus_if.done_o, 0);
        check("rst_result", bus_if.result_o, 0);
        rst = 1'b0;

        @(negedge clk);
        kick(8'h29, 8'h7A, KEY_OK);
        wait_done(r, lat, bc);
        check("ok_result", r, 16'h138A);
        check("ok_latency", lat, 8);
        check("ok_busy_cycles", bc, 8);
        @(negedge clk);
        check("done_one_cycle", bus_if.done_o, 0);

        mul("wrong_bit2", 8'h29, 8'h7A, 64'h192F7F0351667DE8, 16'h142E);
        mul("cancel_0_8", 8'h29, 8'h7A, 64'h192F7F0351667CED, 16'h138A);
        mul("flip_24", 8'h29, 8'h7A, 64'h190F7F0351627DEC, 16'h0F0E);
        mul("ff_ff", 8'hFF, 8'hFF, KEY_OK, 16'hFE01);
        mul("80_80", 8'h80, 8'h80, KEY_OK, 16'h4000);
        mul("ab_00", 8'hAB, 8'h00, KEY_OK, 16'h0000);
        mul("00_01", 8'h00, 8'h01, KEY_OK, 16'h0000);

        // Back-to-back through DONE.
        @(negedge clk);
        kick(8'h11, 8'h11, KEY_OK);
        wait_done(r, lat, bc);
        check("b2b_first", r, 16'h0121);
        kick(8'h34, 8'h12, KEY_OK);
        wait_done(r, lat, bc);
        check("b2b_second", r, 16'h03A8);
        check("b2b_gap", lat + 1, 9);

        // Mid-RUN start pulse and operand/key changes are ignored.
        @(negedge clk);
        kick(8'h29, 8'h7A, KEY_OK);
        repeat (3) @(negedge clk);
        bus_if.operand1_i = 8'hFF;
        bus_if.operand2_i = 8'hFF;
        bus_if.keyinput   = 64'h0;
        bus_if.start_i    = 1'b1;
        @(negedge clk);
        bus_if.start_i    = 1'b0;
        wait_done(r, lat, bc);
        check("midrun_result", r, 16'h138A);
        check("midrun_latency", lat + 4, 8);
        @(negedge clk);
        check("midrun_not_queued", bus_if.busy_o, 0);

        // Asynchronous reset four cycles into RUN.
        @(negedge clk);
        kick(8'h11, 8'h11, KEY_OK);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", bus_if.busy_o, 0);
        check("arst_result", bus_if.result_o, 0);
        check("arst_done", bus_if.done_o, 0);
        done_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus_if.done_o) done_seen++;
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        if (bus_if.done_o) done_seen++;
        check("arst_no_done", done_seen, 0);
        mul("post_rst", 8'h40, 8'h20, KEY_OK, 16'h0800);

        check("busy_done_exclusive", both_high, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
